// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding, default
// operand width, step-counter width and the execute-stage aluop codes.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  // aluop codes decoded for div / divu
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic             no_borrow;
  logic [WIDTH-1:0] diff;

  // rem < divisor on entry, so a successful difference always fits in WIDTH
  // bits and the low bits of a modular subtraction are exact.
  always_comb begin
    shifted   = {rem_i, bit_i};
    no_borrow = (shifted >= {1'b0, divisor_i});
    diff      = shifted[WIDTH-1:0] - divisor_i;
    q_o       = no_borrow;
    rem_o     = no_borrow ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle divider sequencer for MIPS div/divu: one quotient bit per clock,
// result = {remainder, quotient}. Optional build macro DIV_EARLY_EXIT_EN
// finishes immediately when the dividend magnitude is below the divisor's.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dq_q, dq_d;      // dividend bits shifted out, quotient bits shifted in
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic               req, divisor_zero, early_exit, last_step;
  logic [WIDTH-1:0]   step_rem, q_new, q_fix, r_fix;
  logic               step_q;

  assign req          = start_i & ~annul_i;
  assign divisor_zero = (opdata2_i == '0);
  assign dvd_mag      = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign dvs_mag      = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_EXIT_EN
  assign early_exit   = (dvd_mag < dvs_mag);
`else
  assign early_exit   = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign q_new     = {dq_q[WIDTH-2:0], step_q};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign q_fix     = neg_quot_q ? -q_new : q_new;
  assign r_fix     = neg_rem_q ? -step_rem : step_rem;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; annul wins over everything in the active states
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (divisor_zero)    state_d = BYZERO;
          else if (early_exit) state_d = END;
          else                 state_d = ON;
        end
      end
      BYZERO:  state_d = annul_i ? IDLE : END;
      ON: begin
        if (annul_i)        state_d = IDLE;
        else if (last_step) state_d = END;
      end
      END:     if (!start_i || annul_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath and output updates per state
  always_comb begin
    cnt_d      = cnt_q;
    dq_d       = dq_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      IDLE: begin
        if (req && !divisor_zero) begin
          cnt_d      = '0;
          dq_d       = dvd_mag;
          rem_d      = '0;
          dvs_d      = dvs_mag;
          neg_quot_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
          if (early_exit) begin
            result_d = {opdata1_i, {WIDTH{1'b0}}};
            ready_d  = 1'b1;
          end
        end
      end
      BYZERO: begin
        if (!annul_i) begin
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (!annul_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          dq_d  = q_new;
          rem_d = step_rem;
          if (last_step) begin
            result_d = {r_fix, q_fix};
            ready_d  = 1'b1;
          end
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dq_q       <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dq_q       <= dq_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == ON) || (state_q == BYZERO);

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random operands checked
// against an arithmetic reference (64-bit integer divide, truncating toward zero).
module tb_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int checks   = 0;
  int failures = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {remainder, quotient}; divide by zero yields 0
  function automatic logic [63:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint na, nb, q, r;
    if (b == '0) return 64'd0;
    if (s) begin
      na = $signed(a);
      nb = $signed(b);
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // edges after E until ready_o is seen
  function automatic int model_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint na, nb;
    if (b == '0) return 1;
    na = s ? longint'($signed(a)) : longint'({32'd0, a});
    nb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (na < 0) na = -na;
    if (nb < 0) nb = -nb;
`ifdef DIV_EARLY_EXIT_EN
    if (na < nb) return 0;
`endif
    return W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp, input bit hold);
    int lat, n, busy_n;
    bit early_junk;
    lat = model_lat(s, a, b);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    tick();  // edge E
    // operands change after latching; the result must not depend on them
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    n = 0;
    busy_n = 0;
    early_junk = 1'b0;
    while (!ready_o && n < W + 4) begin
      if (busy_o) busy_n++;
      if (result_o !== '0) early_junk = 1'b1;
      tick();
      n++;
    end
    $display("op %s s=%0d a=%h b=%h result=%h latency=%0d", tag, s, a, b, result_o, n);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat));
    check({tag, " result_zero_before_ready"}, 64'(early_junk), 64'd0);
    check({tag, " result"}, result_o, exp);
    check({tag, " busy_at_ready"}, 64'(busy_o), 64'd0);
    if (hold) begin
      tick();
      check({tag, " hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, " hold_result"}, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    check({tag, " drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, " drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic       s;
    logic [W-1:0] a, b;
    int         n;
    bit         bad;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick();
    tick();
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7",     1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b1);
    run_op("div_m7_2",       1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("div_min_m1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 1'b1);
    run_op("divu_max_1",     1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 1'b0);
    run_op("div_5_0",        1'b1, 32'd5,          32'd0,          64'd0,                 1'b1);
    run_op("divu_5_0",       1'b0, 32'd5,          32'd0,          64'd0,                 1'b0);
    run_op("divu_3_10",      1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 1'b1);
    run_op("div_m3_10",      1'b1, 32'hFFFF_FFFD,  32'd10,         64'hFFFFFFFD_00000000, 1'b0);

    // annul at step 10, then an immediate new request
    signed_div_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5; start_i = 1'b1;
    tick();  // edge E
    bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (ready_o) bad = 1'b1;
      tick();
    end
    annul_i = 1'b1;
    tick();  // edge E+10
    check("annul ready_never", 64'(bad | ready_o), 64'd0);
    check("annul busy", 64'(busy_o), 64'd0);
    check("annul result", result_o, 64'd0);
    annul_i = 1'b0;
    run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

    // start and annul together in IDLE: nothing starts
    signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    tick();
    check("start_annul busy", 64'(busy_o), 64'd0);
    tick();
    tick();
    check("start_annul ready", 64'(ready_o), 64'd0);
    check("start_annul busy_later", 64'(busy_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    tick();

    // annul while in BYZERO
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick();
    check("byzero busy", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    tick();
    check("byzero_annul busy", 64'(busy_o), 64'd0);
    check("byzero_annul ready", 64'(ready_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    tick();
    check("byzero_annul ready_later", 64'(ready_o), 64'd0);

    // annul while in END with start held
    opdata1_i = 32'd40; opdata2_i = 32'd6; start_i = 1'b1;
    tick();
    n = 0;
    while (!ready_o && n < W + 4) begin
      tick();
      n++;
    end
    check("end_annul reached", 64'(ready_o), 64'd1);
    check("end_annul result", result_o, 64'h00000004_00000006);
    annul_i = 1'b1;
    tick();
    check("end_annul ready", 64'(ready_o), 64'd0);
    check("end_annul result_cleared", result_o, 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    tick();

    // reset in the middle of ON
    opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("mid_on busy", 64'(busy_o), 64'd1);
    rst = 1'b1; start_i = 1'b0;
    tick();
    check("mid_rst busy", 64'(busy_o), 64'd0);
    check("mid_rst ready", 64'(ready_o), 64'd0);
    check("mid_rst result", result_o, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();
    check("post_rst ready", 64'(ready_o), 64'd0);

    // random operands against the arithmetic reference
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 50));
        2:       a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: a = -32'($urandom_range(0, 50));
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 20));
        4:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op("rand", s, a, b, model(s, a, b), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
